// File: rtl/train_sequencer.sv
// train_sequencer: epoch-level training FSM sequencing the output neuron and the backprop unit
//   clk_i, rst_i          clock (rising edge), asynchronous active-low reset
//   start_i, abort_i      run control from the chip I/O controller
//   loss_i                neuron loss register
//   zero_end_check_i      neuron zero-output/zero-target shortcut
//   bp_done_i             backprop weight update finished
//   en_o                  neuron enable, high for FWD_CYCLES per forward pass
//   zero_final_o          clear neuron final register
//   zero_loss_o           clear neuron loss register
//   bp_start_o            one-cycle backprop launch pulse
//   busy_o, done_o        run in progress / run finished
//   converged_o, error_o  result flags, valid while done_o
//   epoch_o               completed-epoch count
//   state_o               IDLE=0 CLEAR=1 FWD=2 EVAL=3 BPASS=4 DONE=5
module train_sequencer #(
  parameter int          EPOCH_W     = 4,
  parameter int          FWD_CYCLES  = 2,
  parameter logic [45:0] LOSS_THRESH = '0,
  parameter int          BP_TIMEOUT  = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [45:0]        loss_i,
  input  logic               zero_end_check_i,
  input  logic               bp_done_i,
  output logic               en_o,
  output logic               zero_final_o,
  output logic               zero_loss_o,
  output logic               bp_start_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               converged_o,
  output logic               error_o,
  output logic [EPOCH_W-1:0] epoch_o,
  output logic [2:0]         state_o
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FWD   = 3'd2,
    EVAL  = 3'd3,
    BPASS = 3'd4,
    DONE  = 3'd5
  } state_t;
  localparam int FCW = $clog2(FWD_CYCLES);
  state_t         state, nxt;
  logic [FCW-1:0] fcnt;
  logic [7:0]     wcnt;
  logic           conv;
  assign conv    = zero_end_check_i || loss_i <= LOSS_THRESH;
  assign state_o = state;
  // bp_start_o is high only in the first BPASS cycle, so it doubles as the
  // "ignore bp_done_i this cycle" marker
  always_comb begin
    nxt = state;
    if (abort_i) nxt = IDLE;
    else
      case (state)
        IDLE, DONE: nxt = start_i ? CLEAR : state;
        CLEAR:      nxt = FWD;
        FWD:        nxt = fcnt == '0 ? EVAL : FWD;
        EVAL:       nxt = (conv || epoch_o == {EPOCH_W{1'b1}}) ? DONE : BPASS;
        BPASS:      nxt = (!bp_start_o && bp_done_i) ? CLEAR :
                          wcnt == 8'(BP_TIMEOUT) ? DONE : BPASS;
        default:    nxt = IDLE;
      endcase
  end
  // all outputs are registered from the next-state value so they line up
  // with state_o and never depend combinationally on inputs
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state        <= IDLE;
      en_o         <= 1'b0;
      zero_final_o <= 1'b0;
      zero_loss_o  <= 1'b0;
      bp_start_o   <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      converged_o  <= 1'b0;
      error_o      <= 1'b0;
      epoch_o      <= '0;
      fcnt         <= '0;
      wcnt         <= '0;
    end else begin
      state        <= nxt;
      en_o         <= nxt == FWD;
      zero_final_o <= nxt == CLEAR;
      zero_loss_o  <= nxt == CLEAR;
      bp_start_o   <= nxt == BPASS && state != BPASS;
      busy_o       <= nxt inside {CLEAR, FWD, EVAL, BPASS};
      done_o       <= nxt == DONE;
      fcnt         <= state == CLEAR ? FCW'(FWD_CYCLES - 1) : fcnt - FCW'(state == FWD);
      wcnt         <= state == BPASS ? wcnt + 8'd1 : 8'd0;
      if (nxt == CLEAR && (state == IDLE || state == DONE)) begin
        epoch_o     <= '0;
        converged_o <= 1'b0;
        error_o     <= 1'b0;
      end
      if (state == BPASS && nxt == CLEAR) epoch_o <= epoch_o + 1'b1;
      if (state == EVAL && nxt == DONE) converged_o <= conv;
      if (state == BPASS && nxt == DONE) error_o <= 1'b1;
      if (abort_i) begin
        converged_o <= 1'b0;
        error_o     <= 1'b0;
      end
    end
endmodule

// File: tb/tb_train_sequencer.sv
// tb_train_sequencer: directed self-checking bench for train_sequencer
module tb_train_sequencer;
  logic        clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, abort_i = 1'b0;
  logic [45:0] loss_i = '0;
  logic        zero_end_check_i = 1'b0, bp_done_i = 1'b0;
  logic        en_o, zero_final_o, zero_loss_o, bp_start_o, busy_o, done_o, converged_o, error_o;
  logic [1:0]  epoch_o;
  logic [2:0]  state_o;
  int total = 0, bad = 0;

  train_sequencer #(.EPOCH_W(2), .FWD_CYCLES(2), .LOSS_THRESH(46'd0), .BP_TIMEOUT(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i), .loss_i(loss_i),
    .zero_end_check_i(zero_end_check_i), .bp_done_i(bp_done_i), .en_o(en_o),
    .zero_final_o(zero_final_o), .zero_loss_o(zero_loss_o), .bp_start_o(bp_start_o),
    .busy_o(busy_o), .done_o(done_o), .converged_o(converged_o), .error_o(error_o),
    .epoch_o(epoch_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [14:0] outs();
    return {en_o, zero_final_o, zero_loss_o, bp_start_o, busy_o, done_o, converged_o, error_o, epoch_o, state_o};
  endfunction

  task automatic test_reset();
    #12;
    total++; if (outs() !== 15'd0) begin bad++; $display("FAIL reset_outs got=%h exp=0", outs()); end
    step();
    total++; if (state_o !== 3'd0) begin bad++; $display("FAIL reset_idle_clocked got=%0d exp=0", state_o); end
    rst_i = 1'b1;
    step();
  endtask

  task automatic test_converge_first();
    logic [2:0] seq [5];
    logic [2:0] exp_seq [5] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd5};
    int en_cnt = 0;
    loss_i = 46'd0;
    start_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start_i = 1'b0;
      seq[i] = state_o;
      en_cnt += int'(en_o);
      if (i == 0) begin
        total++; if ({zero_final_o, zero_loss_o, en_o, busy_o} !== 4'b1101) begin bad++; $display("FAIL clear_outs got=%b exp=1101", {zero_final_o, zero_loss_o, en_o, busy_o}); end
      end
    end
    for (int i = 0; i < 5; i++) begin
      total++; if (seq[i] !== exp_seq[i]) begin bad++; $display("FAIL t1_state[%0d] got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
    end
    total++; if (en_cnt !== 2) begin bad++; $display("FAIL t1_en_cycles got=%0d exp=2", en_cnt); end
    total++; if ({done_o, converged_o, error_o, busy_o} !== 4'b1100) begin bad++; $display("FAIL t1_flags got=%b exp=1100", {done_o, converged_o, error_o, busy_o}); end
    total++; if (epoch_o !== 2'd0) begin bad++; $display("FAIL t1_epoch got=%0d exp=0", epoch_o); end
  endtask

  task automatic test_one_bp();
    int pulses = 0;
    loss_i = 46'd100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if ({state_o, converged_o} !== {3'd1, 1'b0}) begin bad++; $display("FAIL t2_restart got=%0d/%b exp=1/0", state_o, converged_o); end
    for (int i = 0; i < 10 && state_o !== 3'd4; i++) step();
    total++; if ({state_o, bp_start_o} !== {3'd4, 1'b1}) begin bad++; $display("FAIL t2_bp_launch got=%0d/%b exp=4/1", state_o, bp_start_o); end
    pulses += int'(bp_start_o);
    step();
    total++; if (bp_start_o !== 1'b0) begin bad++; $display("FAIL t2_pulse_width got=%b exp=0", bp_start_o); end
    step();
    bp_done_i = 1'b1;
    loss_i = 46'd0;
    step();
    bp_done_i = 1'b0;
    total++; if ({state_o, epoch_o} !== {3'd1, 2'd1}) begin bad++; $display("FAIL t2_epoch_step got=%0d/%0d exp=1/1", state_o, epoch_o); end
    for (int i = 0; i < 20 && !done_o; i++) begin step(); pulses += int'(bp_start_o); end
    total++; if (pulses !== 1) begin bad++; $display("FAIL t2_pulses got=%0d exp=1", pulses); end
    total++; if ({done_o, converged_o, epoch_o} !== {1'b1, 1'b1, 2'd1}) begin bad++; $display("FAIL t2_result got=%b exp=111", {done_o, converged_o, epoch_o}); end
  endtask

  task automatic test_epoch_limit();
    int pulses = 0;
    loss_i = 46'd100;
    bp_done_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 100 && !done_o; i++) begin step(); pulses += int'(bp_start_o); end
    bp_done_i = 1'b0;
    total++; if (pulses !== 3) begin bad++; $display("FAIL t3_pulses got=%0d exp=3", pulses); end
    total++; if ({done_o, converged_o, error_o, epoch_o} !== {3'b100, 2'd3}) begin bad++; $display("FAIL t3_result got=%b exp=10011", {done_o, converged_o, error_o, epoch_o}); end
  endtask

  task automatic test_timeout();
    loss_i = 46'd100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10 && state_o !== 3'd4; i++) step();
    bp_done_i = 1'b1;
    step();
    bp_done_i = 1'b0;
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL t4_first_cycle_done_ignored got=%0d exp=4", state_o); end
    for (int i = 0; i < 4; i++) step();
    total++; if (state_o !== 3'd4) begin bad++; $display("FAIL t4_still_waiting got=%0d exp=4", state_o); end
    step();
    total++; if ({state_o, done_o, error_o, converged_o, epoch_o} !== {3'd5, 3'b110, 2'd0}) begin bad++; $display("FAIL t4_timeout got=%0d/%b%b%b/%0d exp=5/110/0", state_o, done_o, error_o, converged_o, epoch_o); end
  endtask

  task automatic test_abort();
    loss_i = 46'd100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if ({state_o, error_o} !== {3'd1, 1'b0}) begin bad++; $display("FAIL t5_flags_cleared got=%0d/%b exp=1/0", state_o, error_o); end
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    total++; if ({state_o, en_o, busy_o} !== {3'd0, 2'b00}) begin bad++; $display("FAIL t5_abort_fwd got=%0d/%b%b exp=0/00", state_o, en_o, busy_o); end
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 10 && state_o !== 3'd4; i++) step();
    step();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    total++; if ({state_o, bp_start_o} !== {3'd4, 1'b0}) begin bad++; $display("FAIL t5_start_in_bpass got=%0d/%b exp=4/0", state_o, bp_start_o); end
    bp_done_i = 1'b1;
    step();
    bp_done_i = 1'b0;
    total++; if ({state_o, epoch_o} !== {3'd1, 2'd1}) begin bad++; $display("FAIL t5_epoch1 got=%0d/%0d exp=1/1", state_o, epoch_o); end
    for (int i = 0; i < 10 && state_o !== 3'd4; i++) step();
    step();
    abort_i = 1'b1;
    bp_done_i = 1'b1;
    step();
    abort_i = 1'b0;
    bp_done_i = 1'b0;
    total++; if ({state_o, epoch_o, busy_o} !== {3'd0, 2'd1, 1'b0}) begin bad++; $display("FAIL t5_abort_beats_done got=%0d/%0d/%b exp=0/1/0", state_o, epoch_o, busy_o); end
  endtask

  task automatic test_async_reset();
    loss_i = 46'd100;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    total++; if ({state_o, en_o} !== {3'd2, 1'b1}) begin bad++; $display("FAIL t6_in_fwd got=%0d/%b exp=2/1", state_o, en_o); end
    #2 rst_i = 1'b0;
    #1;
    total++; if (outs() !== 15'd0) begin bad++; $display("FAIL t6_async_reset got=%h exp=0", outs()); end
    rst_i = 1'b1;
    zero_end_check_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 20 && !done_o; i++) step();
    zero_end_check_i = 1'b0;
    total++; if ({state_o, converged_o, error_o, epoch_o} !== {3'd5, 2'b10, 2'd0}) begin bad++; $display("FAIL t6_zero_check got=%0d/%b%b/%0d exp=5/10/0", state_o, converged_o, error_o, epoch_o); end
  endtask

  initial begin
    test_reset();
    test_converge_first();
    test_one_bp();
    test_epoch_limit();
    test_timeout();
    test_abort();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
